// File: rtl/izh_spike_decoder_pkg.sv
// Shared types and constants for the spike decoder.
// Q2.6 values have 6 fractional bits, so 1 LSB = 1/64.
package izh_pkg;

  typedef logic signed [7:0] q2_6_t;

  // Spike threshold of about 0.30
  localparam q2_6_t IZH_V_THRESH = 8'sd19;
  // Re-arm level of -0.5
  localparam q2_6_t IZH_V_REARM  = -8'sd32;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } izh_state_e;

endpackage

// File: rtl/izh_spike_decoder_if.sv
// Spike event port.
// Handshake: the producer raises ev_valid and holds ev_isi, ev_first and ev_burst
// stable until a cycle in which ev_valid and ev_ready are both 1. That cycle is the
// transfer. ev_ready may depend on nothing from the producer except ev_valid.
interface izh_spike_decoder_if #(
  parameter int ISI_W = 12
);
  logic             ev_valid;
  logic             ev_ready;
  logic [ISI_W-1:0] ev_isi;
  logic             ev_first;
  logic             ev_burst;

  modport master (output ev_valid, output ev_isi, output ev_first, output ev_burst,
                  input ev_ready);
  modport slave  (input ev_valid, input ev_isi, input ev_first, input ev_burst,
                  output ev_ready);
endinterface

// File: rtl/izh_spike_decoder_isi_timer.sv
// Counts sample strobes since the last spike.
// It saturates at all-ones. A load restarts the count at 1 so that the value seen on
// the next strobe is the spacing in strobes. The owner captures cnt on the spike
// strobe, before the reload takes effect.
module izh_isi_timer #(
  parameter int ISI_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  output logic [ISI_W-1:0] cnt
);

  // Strobe counter with reload to 1 and saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ena) begin
      if (load) begin
        cnt <= ISI_W'(1);
      end else if (cnt != {ISI_W{1'b1}}) begin
        cnt <= cnt + ISI_W'(1);
      end
    end
  end

endmodule

// File: rtl/izh_spike_decoder.sv
// Spike decoder for the neuron membrane-potential stream.
// It detects threshold crossings with hysteresis, measures the inter-spike interval
// and flags bursts. It emits one event per spike through a single-entry buffer.
// Optional feature macro: IZH_SPIKE_RATE_EN. It adds a windowed spike-rate output;
// without the macro, rate is 0.
module izh_spike_decoder
  import izh_pkg::*;
#(
  parameter q2_6_t THRESH        = IZH_V_THRESH,
  parameter q2_6_t REARM         = IZH_V_REARM,
  parameter int    ISI_W         = 12,
  parameter int    BURST_ISI     = 8,
  parameter int    RATE_WIN_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  q2_6_t                  v_in,
  output logic                   spike_pulse,
  output logic                   overflow,
  output logic [RATE_WIN_LOG2:0] rate,
  output izh_state_e             fsm_state,
  izh_spike_decoder_if.master    ev
);

  izh_state_e       state_q, state_d;
  logic             spike;
  logic [ISI_W-1:0] isi_cnt;
  logic             have_prev;
  logic             valid_q, first_q, burst_q;
  logic [ISI_W-1:0] isi_q;
  logic             accept;

  assign fsm_state   = state_q;
  assign ev.ev_valid = valid_q;
  assign ev.ev_isi   = isi_q;
  assign ev.ev_first = first_q;
  assign ev.ev_burst = burst_q;

  // Detector state register; reset lands in FIRED so no spike fires straight out of reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= FIRED;
    else     state_q <= state_d;
  end

  // Hysteresis next-state and spike decode; only strobed samples are considered
  always_comb begin
    state_d = state_q;
    spike   = 1'b0;
    if (ena) begin
      case (state_q)
        ARMED: if (v_in > THRESH) begin
          spike   = 1'b1;
          state_d = FIRED;
        end
        FIRED: if (v_in < REARM) state_d = ARMED;
        default: state_d = FIRED;
      endcase
    end
  end

  izh_isi_timer #(.ISI_W(ISI_W)) u_isi_timer (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .load (spike),
    .cnt  (isi_cnt)
  );

  // A new event fits when the buffer is empty or is being drained this cycle
  assign accept = spike && (!valid_q || ev.ev_ready);

  // Event buffer, spike pulse and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      isi_q       <= '0;
      first_q     <= 1'b0;
      burst_q     <= 1'b0;
      spike_pulse <= 1'b0;
      overflow    <= 1'b0;
      have_prev   <= 1'b0;
    end else begin
      spike_pulse <= spike;
      if (spike) have_prev <= 1'b1;
      if (accept) begin
        valid_q <= 1'b1;
        first_q <= !have_prev;
        isi_q   <= have_prev ? isi_cnt : '0;
        burst_q <= have_prev && (isi_cnt <= ISI_W'(BURST_ISI));
      end else if (valid_q && ev.ev_ready) begin
        valid_q <= 1'b0;
        isi_q   <= '0;
        first_q <= 1'b0;
        burst_q <= 1'b0;
      end
      if (spike && valid_q && !ev.ev_ready) overflow <= 1'b1;
    end
  end

`ifdef IZH_SPIKE_RATE_EN
  localparam logic [RATE_WIN_LOG2:0] SPK_MAX = (RATE_WIN_LOG2+1)'(1) << RATE_WIN_LOG2;

  logic [RATE_WIN_LOG2-1:0] win_cnt;
  logic [RATE_WIN_LOG2:0]   spk_cnt, spk_next, rate_q;

  // Spike count including the current strobe, saturating at one full window
  always_comb begin
    spk_next = spk_cnt;
    if (spike && spk_cnt != SPK_MAX) spk_next = spk_cnt + (RATE_WIN_LOG2+1)'(1);
  end

  // Window counter; on the wrap strobe, publish the count and start afresh
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt <= '0;
      spk_cnt <= '0;
      rate_q  <= '0;
    end else if (ena) begin
      win_cnt <= win_cnt + RATE_WIN_LOG2'(1);
      if (&win_cnt) begin
        rate_q  <= spk_next;
        spk_cnt <= '0;
      end else begin
        spk_cnt <= spk_next;
      end
    end
  end

  assign rate = rate_q;
`else
  assign rate = '0;
`endif

endmodule
